// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register.
// Latency: a word accepted at edge N is on InstD after edge N (one cycle).
// Backpressure: Stall or IMemValid=0 holds the PC; Flush, memory wait and redirect insert bubbles.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  input  logic        IMemValid,
  output logic [31:0] InstD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  // PC is kept as a word address; the two byte-offset bits are always zero.
  logic [29:0] pc_q, pc_d;
  logic [31:0] pc_full;
  logic [31:0] pc_plus4;

  logic [31:0] inst_q, inst_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4_q, pc4_d;
  logic        vld_q, vld_d;

  // Redirect targets are forced word-aligned, so their low bits are ignored.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^PCTarget[1:0];

  assign pc_full  = {pc_q, 2'b00};
  // Word-address increment wraps modulo 2^32 with no carry out.
  assign pc_plus4 = {pc_q + 30'd1, 2'b00};
  assign IMemAddr = pc_full;

  // Next PC: redirect beats stall, stall and memory wait both hold.
  always_comb begin
    pc_d = pc_q;
    if (PCSrc) begin
      pc_d = PCTarget[31:2];
    end else if (Stall || !IMemValid) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + 30'd1;
    end
  end

  // Next IF/ID contents: flush beats stall; a wait or redirect discards the word.
  always_comb begin
    inst_d = inst_q;
    pcd_d  = pcd_q;
    pc4_d  = pc4_q;
    vld_d  = vld_q;
    if (Flush) begin
      inst_d = NOP_INST;
      pcd_d  = 32'h0;
      pc4_d  = 32'h0;
      vld_d  = 1'b0;
    end else if (Stall) begin
      inst_d = inst_q;
      pcd_d  = pcd_q;
      pc4_d  = pc4_q;
      vld_d  = vld_q;
    end else if (!IMemValid || PCSrc) begin
      inst_d = NOP_INST;
      pcd_d  = 32'h0;
      pc4_d  = 32'h0;
      vld_d  = 1'b0;
    end else begin
      inst_d = IMemData;
      pcd_d  = pc_full;
      pc4_d  = pc_plus4;
      vld_d  = 1'b1;
    end
  end

  // State update; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC[31:2];
      inst_q <= NOP_INST;
      pcd_q  <= 32'h0;
      pc4_q  <= 32'h0;
      vld_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
      pcd_q  <= pcd_d;
      pc4_q  <= pc4_d;
      vld_q  <= vld_d;
    end
  end

  assign InstD    = inst_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pc4_q;
  assign ValidD   = vld_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory word at byte address A is A>>2.
// Every check compares {IMemAddr, InstD, PCD, PCPlus4D, ValidD} against a hand-derived value.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall;
  logic        Flush;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic        IMemValid;
  logic [31:0] InstD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int checks = 0;
  int failures = 0;

  logic [128:0] obs;
  logic [128:0] exp_v;

  fetch_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Stall    (Stall),
    .Flush    (Flush),
    .PCSrc    (PCSrc),
    .PCTarget (PCTarget),
    .IMemAddr (IMemAddr),
    .IMemData (IMemData),
    .IMemValid(IMemValid),
    .InstD    (InstD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

  always #5 clk = ~clk;

  assign IMemData = {2'b00, IMemAddr[31:2]};
  assign obs      = {IMemAddr, InstD, PCD, PCPlus4D, ValidD};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Stall     = 1'b0;
    Flush     = 1'b0;
    PCSrc     = 1'b0;
    PCTarget  = 32'h0;
    IMemValid = 1'b1;
  endtask

  // Reset for two edges then release; PC is 0 and nothing accepted yet.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n     = 1'b0;
    Stall     = 1'b1;
    PCSrc     = 1'b1;
    PCTarget  = 32'h0000_0500;
    step();
    step();
    exp_v = {32'h0, NOP, 32'h0, 32'h0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL reset_state got %h want %h", obs, exp_v);
    end
    idle_inputs();
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL reset_release got %h want %h", obs, exp_v);
    end
  endtask

  // Straight-line stream: after k edges PC=4k and InstD holds word k-1.
  task automatic test_stream();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_v = {32'(4*k), 32'(k-1), 32'(4*(k-1)), 32'(4*k), 1'b1};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL stream[%0d] got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 4; k++) step();
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      exp_v = {32'h10, 32'h3, 32'h0C, 32'h10, 1'b1};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL stall_hold[%0d] got %h want %h", k, obs, exp_v);
      end
    end
    Stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      exp_v = {32'(32'h14 + 4*k), 32'(4 + k), 32'(32'h10 + 4*k), 32'(32'h14 + 4*k), 1'b1};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL stall_release[%0d] got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int k = 0; k < 8; k++) step();
    PCSrc    = 1'b1;
    PCTarget = 32'h0000_0103;
    step();
    exp_v = {32'h100, NOP, 32'h0, 32'h0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL redirect_bubble got %h want %h", obs, exp_v);
    end
    PCSrc = 1'b0;
    step();
    exp_v = {32'h104, 32'h40, 32'h100, 32'h104, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL redirect_target got %h want %h", obs, exp_v);
    end
    // Redirect during stall: PC moves, IF/ID holds.
    Stall    = 1'b1;
    PCSrc    = 1'b1;
    PCTarget = 32'h0000_0200;
    step();
    exp_v = {32'h200, 32'h40, 32'h100, 32'h104, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL redirect_in_stall got %h want %h", obs, exp_v);
    end
    Stall = 1'b0;
    PCSrc = 1'b0;
    step();
    exp_v = {32'h204, 32'h80, 32'h200, 32'h204, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL redirect_after_stall got %h want %h", obs, exp_v);
    end
  endtask

  // Continues from test_redirect: PC=0x204, InstD=word from 0x200.
  task automatic test_flush_stall();
    Flush = 1'b1;
    Stall = 1'b1;
    step();
    exp_v = {32'h204, NOP, 32'h0, 32'h0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL flush_stall got %h want %h", obs, exp_v);
    end
    Flush = 1'b0;
    Stall = 1'b0;
    step();
    exp_v = {32'h208, 32'h81, 32'h204, 32'h208, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL flush_stall_release got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int k = 0; k < 16; k++) step();
    IMemValid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      exp_v = {32'h40, NOP, 32'h0, 32'h0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL mem_wait[%0d] got %h want %h", k, obs, exp_v);
      end
    end
    IMemValid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      exp_v = {32'(32'h44 + 4*k), 32'(16 + k), 32'(32'h40 + 4*k), 32'(32'h44 + 4*k), 1'b1};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL mem_resume[%0d] got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_wrap_midreset();
    do_reset();
    PCSrc    = 1'b1;
    PCTarget = 32'hFFFF_FFFC;
    step();
    PCSrc = 1'b0;
    exp_v = {32'hFFFF_FFFC, NOP, 32'h0, 32'h0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL wrap_load got %h want %h", obs, exp_v);
    end
    step();
    exp_v = {32'h0, 32'h3FFF_FFFF, 32'hFFFF_FFFC, 32'h0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL wrap_advance got %h want %h", obs, exp_v);
    end
    step();
    exp_v = {32'h4, 32'h0, 32'h0, 32'h4, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL wrap_continue got %h want %h", obs, exp_v);
    end
    rst_n    = 1'b0;
    PCSrc    = 1'b1;
    Stall    = 1'b1;
    PCTarget = 32'h0000_0300;
    step();
    exp_v = {32'h0, NOP, 32'h0, 32'h0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL mid_reset got %h want %h", obs, exp_v);
    end
    rst_n = 1'b1;
    idle_inputs();
    step();
    exp_v = {32'h4, 32'h0, 32'h0, 32'h4, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL post_mid_reset got %h want %h", obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_flush_stall();
    test_mem_wait();
    test_wrap_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
